// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the radix-4 Booth sequential multiplier.
package booth_pkg;

    localparam int DEF_N = 12;

    // Counter width for N/2 Booth digits; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n / 2 > 1) ? $clog2(n / 2) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_N);

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } booth_digit_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic booth_digit_e booth_decode(input logic [2:0] triplet);
        booth_digit_e d;
        case (triplet)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// rtl/booth_pp_sel.sv - combinational radix-4 Booth partial-product selector.
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [2:0]   triplet,
    input  logic [N-1:0] a,
    output logic [N+1:0] pp
);

    // Two guard bits so that -2A of the most negative A still fits.
    logic [N+1:0]  a_ext;
    booth_digit_e  digit;

    assign a_ext = {{2{a[N-1]}}, a};
    assign digit = booth_decode(triplet);

    always_comb begin
        pp = '0;
        case (digit)
            P1:      pp = a_ext;
            P2:      pp = a_ext << 1;
            M1:      pp = -a_ext;
            M2:      pp = -(a_ext << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - iterative radix-4 Booth signed multiplier, one digit per clock.
// Optional BOOTH_MAC_EN adds acc_en: accumulate onto the previous product.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
`ifdef BOOTH_MAC_EN
    input  logic           acc_en,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int        CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N:0]       b_q, b_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             out_valid_q, out_valid_d;

    logic [N+1:0]     pp;
    logic [2*N-1:0]   pp_ext;
    logic [2*N-1:0]   pp_shift;
    logic [2*N-1:0]   acc_sum;
    logic [2*N-1:0]   acc_init;

    // b_q holds {B,1'b0} and is shifted right two bits per digit, so the
    // current triplet is always its low three bits.
    booth_pp_sel #(.N(N)) u_pp_sel (
        .triplet (b_q[2:0]),
        .a       (a_q),
        .pp      (pp)
    );

    assign pp_ext   = {{(N-2){pp[N+1]}}, pp};
    assign pp_shift = pp_ext << {count_q, 1'b0};
    assign acc_sum  = acc_q + pp_shift;

`ifdef BOOTH_MAC_EN
    assign acc_init = acc_en ? product_q : '0;
`else
    assign acc_init = '0;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        count_d     = count_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = multiplicand;
                    b_d     = {multiplier, 1'b0};
                    acc_d   = acc_init;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_sum;
                b_d     = {2'b00, b_q[N:2]};
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    product_d   = acc_sum;
                    out_valid_d = 1'b1;
                    count_d     = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule
